// File: rtl/btn_press_decoder.sv
// Classifies debounced button presses into short / long / double-click pulses, timed in ce ticks.
// Optional auto-repeat while held long: define BTN_PRESS_DECODER_REPEAT_EN.
module btn_press_decoder #(
  parameter int LONG_TICKS       = 500,
  parameter int DOUBLE_GAP_TICKS = 250,
  parameter int REPEAT_TICKS     = 100,
  parameter int CNT_W            = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic btn_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG,
    S_GAP,
    S_SECOND
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_TICKS - 1);

  if (LONG_TICKS < 2 || DOUBLE_GAP_TICKS < 2 || REPEAT_TICKS < 2) begin : g_bad_params
    $error("btn_press_decoder: tick parameters must be >= 2");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic             r_busy;
  logic             w_short;
  logic             w_long;
  logic             w_double;
  logic             w_repeat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      r_busy   <= (w_next_state != S_IDLE);
    end
  end

  // Level checks win over the timer, so a release on the terminal tick is still a release.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (btn_level) w_next_state = S_PRESSED;
      end
      S_PRESSED: begin
        if (!btn_level)                   w_next_state = S_GAP;
        else if (ce && r_cnt == LONG_LAST) w_next_state = S_LONG;
        else if (ce)                      w_next_cnt   = r_cnt + CNT_W'(1);
      end
      S_LONG: begin
        if (!btn_level) w_next_state = S_IDLE;
`ifdef BTN_PRESS_DECODER_REPEAT_EN
        else if (ce && r_cnt == CNT_W'(REPEAT_TICKS - 1)) w_next_cnt = '0;
        else if (ce)                                      w_next_cnt = r_cnt + CNT_W'(1);
`endif
      end
      S_GAP: begin
        if (btn_level)                    w_next_state = S_SECOND;
        else if (ce && r_cnt == GAP_LAST) w_next_state = S_IDLE;
        else if (ce)                      w_next_cnt   = r_cnt + CNT_W'(1);
      end
      S_SECOND: begin
        if (!btn_level) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_next_state != r_state) w_next_cnt = '0;
  end

  always_comb begin
    w_long   = (r_state == S_PRESSED) && (w_next_state == S_LONG);
    w_short  = (r_state == S_GAP)     && (w_next_state == S_IDLE);
    w_double = (r_state == S_SECOND)  && (w_next_state == S_IDLE);
`ifdef BTN_PRESS_DECODER_REPEAT_EN
    w_repeat = (r_state == S_LONG) && btn_level && ce && (r_cnt == CNT_W'(REPEAT_TICKS - 1));
`else
    w_repeat = 1'b0;
`endif
  end

`ifdef BTN_PRESS_DECODER_REPEAT_EN
  logic r_repeat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_repeat <= 1'b0;
    else     r_repeat <= w_repeat;
  end

  assign repeat_pulse = r_repeat;
`else
  logic w_repeat_unused;
  assign w_repeat_unused = w_repeat;
  assign repeat_pulse    = 1'b0;
`endif

  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign double_pulse = r_double;
  assign busy         = r_busy;

endmodule

// File: tb/tb_btn_press_decoder.sv
// Randomized and directed bench for btn_press_decoder against a sequence-level reference model.
// Honours BTN_PRESS_DECODER_REPEAT_EN for the auto-repeat expectations.
module tb_btn_press_decoder;

  localparam int LONG = 4;
  localparam int GAP  = 3;
  localparam int REP  = 2;
`ifdef BTN_PRESS_DECODER_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic btnLevel = 1'b0;
  logic shortPulse, longPulse, doublePulse, repeatPulse, busy;

  int checkCount = 0;
  int passCount = 0;
  int shortSeen, longSeen, doubleSeen, repeatSeen;

  // Reference model: tracks a press sequence as a count of presses and ticks since the last edge.
  bit mInSeq, mHeld, mLong;
  int mPresses, mTicks;

  btn_press_decoder #(
    .LONG_TICKS(LONG),
    .DOUBLE_GAP_TICKS(GAP),
    .REPEAT_TICKS(REP),
    .CNT_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .btn_level(btnLevel),
    .short_pulse(shortPulse),
    .long_pulse(longPulse),
    .double_pulse(doublePulse),
    .repeat_pulse(repeatPulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
  endtask

  task automatic modelReset();
    mInSeq = 0; mHeld = 0; mLong = 0; mPresses = 0; mTicks = 0;
  endtask

  task automatic modelStep(input logic btn, input logic ceIn, output logic [4:0] e);
    logic s, l, d, r;
    s = 0; l = 0; d = 0; r = 0;
    if (!mInSeq) begin
      if (btn) begin
        mInSeq = 1; mHeld = 1; mPresses = 1; mLong = 0; mTicks = 0;
      end
    end else if (btn != mHeld) begin
      mHeld = btn;
      mTicks = 0;
      if (!btn) begin
        if (mLong) mInSeq = 0;
        else if (mPresses == 2) begin
          mInSeq = 0; d = 1;
        end
      end else mPresses = 2;
    end else if (ceIn) begin
      if (mHeld && mPresses == 1) begin
        if (!mLong) begin
          mTicks++;
          if (mTicks == LONG) begin
            l = 1; mLong = 1; mTicks = 0;
          end
        end else if (REP_EN) begin
          mTicks++;
          if (mTicks == REP) begin
            r = 1; mTicks = 0;
          end
        end
      end else if (!mHeld) begin
        mTicks++;
        if (mTicks == GAP) begin
          s = 1; mInSeq = 0;
        end
      end
    end
    e = {s, l, d, r, mInSeq};
  endtask

  function automatic logic [15:0] outVec();
    return {11'd0, shortPulse, longPulse, doublePulse, repeatPulse, busy};
  endfunction

  task automatic applyStimulus(input logic btn, input logic ceIn, input string tag);
    logic [4:0] e;
    btnLevel = btn;
    ce = ceIn;
    @(posedge clk);
    modelStep(btn, ceIn, e);
    #1;
    checkOutput(tag, outVec(), {11'd0, e});
    shortSeen  += int'(shortPulse);
    longSeen   += int'(longPulse);
    doubleSeen += int'(doublePulse);
    repeatSeen += int'(repeatPulse);
  endtask

  task automatic hold(input logic btn, input logic ceIn, input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(btn, ceIn, tag);
  endtask

  task automatic clearSeen();
    shortSeen = 0; longSeen = 0; doubleSeen = 0; repeatSeen = 0;
  endtask

  initial begin
    modelReset();
    clearSeen();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetState", outVec(), 16'd0);
    rst = 1'b0;

    // Reset mid-PRESSED must clear outputs asynchronously and drop the sequence.
    hold(1, 1, 2, "rstPress");
    rst = 1'b1;
    #1;
    checkOutput("rstAsync", outVec(), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstHeld", outVec(), 16'd0);
    btnLevel = 1'b0;
    rst = 1'b0;
    modelReset();
    clearSeen();
    hold(0, 1, 6, "postRst");
    checkOutput("postRstPulses", 16'(shortSeen + longSeen + doubleSeen + repeatSeen), 16'd0);

    clearSeen();
    hold(1, 1, 2, "shortHi");
    hold(0, 1, 6, "shortLo");
    checkOutput("shortCount", 16'(shortSeen), 16'd1);
    checkOutput("shortOthers", 16'(longSeen + doubleSeen), 16'd0);

    clearSeen();
    hold(1, 1, 8, "longHi");
    checkOutput("longCount", 16'(longSeen), 16'd1);
    hold(0, 1, 1, "longRel");
    checkOutput("longBusy", 16'(busy), 16'd0);
    hold(0, 1, 5, "longIdle");
    checkOutput("longRelQuiet", 16'(shortSeen + doubleSeen), 16'd0);

    clearSeen();
    hold(1, 1, 2, "dblHi1");
    hold(0, 1, 1, "dblLo1");
    hold(1, 1, 2, "dblHi2");
    hold(0, 1, 5, "dblLo2");
    checkOutput("doubleCount", 16'(doubleSeen), 16'd1);
    checkOutput("doubleNoShort", 16'(shortSeen), 16'd0);

    clearSeen();
    hold(1, 1, 4, "collideHi");
    hold(0, 1, 5, "collideLo");
    checkOutput("collideNoLong", 16'(longSeen), 16'd0);
    checkOutput("collideShort", 16'(shortSeen), 16'd1);

    clearSeen();
    hold(1, 0, 20, "freezeHi");
    checkOutput("freezeNoLong", 16'(longSeen), 16'd0);
    hold(0, 1, 5, "freezeLo");

    clearSeen();
    hold(1, 1, 12, "repeatHi");
    hold(0, 1, 3, "repeatLo");
    checkOutput("repeatLong", 16'(longSeen), 16'd1);
    checkOutput("repeatCount", 16'(repeatSeen), REP_EN ? 16'd3 : 16'd0);

    // Random level runs with a sparse, irregular ce.
    for (int seg = 0; seg < 250; seg++) begin
      logic lvl;
      int len;
      lvl = ~btnLevel;
      len = int'($urandom_range(1, 9));
      for (int k = 0; k < len; k++)
        applyStimulus(lvl, logic'($urandom_range(0, 3) != 0), "random");
      if ($urandom_range(0, 7) == 0) hold(0, 1, 6, "randomIdle");
    end
    hold(0, 1, 8, "flush");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
